// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: LSB-first framing, optional parity, 1 or 2 stop bits.
// Frames go out back to back, and each symbol is paced by the external baud_tick enable.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        baud_tick,
    input  logic                        s_valid,
    input  logic [DATA_BITS-1:0]        s_data,
    output logic                        s_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);
    localparam logic          LAST_STP = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;
    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shreg;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_cnt;
    logic                 r_par;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    assign s_ready    = (r_count != FULL);
    assign w_push     = s_valid && s_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_head     = r_mem[r_rptr];
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);
    assign tx         = r_tx;

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // IDLE re-arms START immediately, so the last stop bit runs until the next tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shreg    <= w_head;
                        r_bit_idx  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_par      <= (PARITY == 2) ? ~^w_head : ^w_head;
                        r_state    <= S_START;
                    end
                end
                S_START: if (baud_tick) begin
                    r_tx    <= 1'b0;
                    r_state <= S_DATA;
                end
                S_DATA: if (baud_tick) begin
                    r_tx <= r_shreg[r_bit_idx];
                    if (r_bit_idx == LAST_IDX) begin
                        r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                S_PAR: if (baud_tick) begin
                    r_tx    <= r_par;
                    r_state <= S_STOP;
                end
                S_STOP: if (baud_tick) begin
                    r_tx <= 1'b1;
                    if (r_stop_cnt == LAST_STP) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_stop_cnt <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations share one clock and tick source;
// a reference receiver per instance decodes tx and checks frames against a scoreboard.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] ten = 4'hF;
    logic [3:0] tg;
    logic [3:0] v = 4'h0;
    logic [7:0] d [4];
    logic [3:0] tx_a, rdy_a, busy_a;
    logic [4:0] c0, c2, c3;
    logic [2:0] c1;

    int total = 0;
    int bad = 0;
    int nstart [4];
    int last_st [4];
    int gap [4];

    typedef struct {int k; logic [8:0] data; logic par;} sb_t;
    sb_t sbq [$];

    typedef struct {int k; logic [7:0] data; logic par;} vec_t;
    vec_t tbl [9];

    assign tg = ten & {4{tick}};

    always #5 clk = ~clk;

    // u0: 8N1/16, u1: 8E2/4, u2: 8O1/16, u3: 7N1/16
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .rst(rst), .baud_tick(tg[0]), .s_valid(v[0]), .s_data(d[0]),
        .s_ready(rdy_a[0]), .fifo_count(c0), .busy(busy_a[0]), .tx(tx_a[0]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .baud_tick(tg[1]), .s_valid(v[1]), .s_data(d[1]),
        .s_ready(rdy_a[1]), .fifo_count(c1), .busy(busy_a[1]), .tx(tx_a[1]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .baud_tick(tg[2]), .s_valid(v[2]), .s_data(d[2]),
        .s_ready(rdy_a[2]), .fifo_count(c2), .busy(busy_a[2]), .tx(tx_a[2]));
    uart_tx_fifo #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u3 (
        .clk(clk), .rst(rst), .baud_tick(tg[3]), .s_valid(v[3]), .s_data(d[3][6:0]),
        .s_ready(rdy_a[3]), .fifo_count(c3), .busy(busy_a[3]), .tx(tx_a[3]));

    // One-cycle tick every 4 clocks, changed away from the active edge.
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            tick = (ph == 0);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic frame_done(input int k, input int pm, input logic [8:0] dd, input logic p);
        int fi = -1;
        foreach (sbq[i]) if (fi < 0 && sbq[i].k == k) fi = i;
        total++;
        if (fi < 0) begin
            bad++;
            $display("FAIL rx%0d unexpected frame got=%h", k, dd);
        end else begin
            if (dd !== sbq[fi].data || (pm != 0 && p !== sbq[fi].par)) begin
                bad++;
                $display("FAIL rx%0d frame got=%h/%b exp=%h/%b", k, dd, p, sbq[fi].data, sbq[fi].par);
            end
            sbq.delete(fi);
        end
    endtask

    // Samples tx one step after each gated tick edge, i.e. the symbol just launched.
    task automatic rx_run(input int k, input int nb, input int pm, input int ns);
        int st = 0, cnt = 0, tk = 0;
        logic [8:0] dd = '0;
        logic p = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin st = 0; continue; end
            if (!tg[k]) continue;
            #1;
            tk++;
            case (st)
                0: if (!tx_a[k]) begin
                    st = 1; cnt = 0; dd = '0;
                    gap[k] = tk - last_st[k]; last_st[k] = tk; nstart[k]++;
                end
                1: begin
                    dd[cnt] = tx_a[k];
                    cnt++;
                    if (cnt == nb) begin cnt = 0; st = (pm != 0) ? 2 : 3; end
                end
                2: begin p = tx_a[k]; st = 3; end
                default: begin
                    total++;
                    if (tx_a[k] !== 1'b1) begin
                        bad++;
                        $display("FAIL rx%0d stop got=%b exp=1", k, tx_a[k]);
                    end
                    cnt++;
                    if (cnt == ns) begin st = 0; frame_done(k, pm, dd, p); end
                end
            endcase
        end
    endtask

    task automatic push(input int k, input logic [7:0] dat, input logic p);
        int n = 0;
        logic [8:0] m;
        m = (k == 3) ? 9'h07F : 9'h0FF;
        @(negedge clk);
        v[k] = 1'b1; d[k] = dat;
        while (!rdy_a[k] && n < 500) begin @(negedge clk); n++; end
        if (!rdy_a[k]) begin
            total++; bad++;
            $display("FAIL push%0d timeout got=0 exp=1", k);
        end else begin
            @(posedge clk);
            sbq.push_back('{k, {1'b0, dat} & m, p});
        end
    endtask

    task automatic drop(input int k);
        @(negedge clk);
        v[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || busy_a != 4'h0) && n < 5000) begin @(negedge clk); n++; end
        chk("drain_pending", sbq.size() + int'(busy_a != 4'h0), 0);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_start(input int k, input int prev);
        int n = 0;
        while (nstart[k] <= prev && n < 2000) begin @(negedge clk); n++; end
        chk("start_seen", int'(nstart[k] > prev), 1);
    endtask

    task automatic wait_ticks(input int k, input int cnt);
        int seen = 0, n = 0;
        while (seen < cnt && n < 500) begin
            @(posedge clk);
            if (tg[k]) seen++;
            n++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        foreach (d[i]) d[i] = 8'h00;
        foreach (nstart[i]) begin nstart[i] = 0; last_st[i] = 0; gap[i] = 0; end
        tbl[0] = '{0, 8'h55, 1'b0};
        tbl[1] = '{1, 8'h07, 1'b1};
        tbl[2] = '{2, 8'h07, 1'b0};
        tbl[3] = '{3, 8'h41, 1'b0};
        tbl[4] = '{0, 8'h00, 1'b0};
        tbl[5] = '{1, 8'hFF, 1'b0};
        tbl[6] = '{2, 8'h80, 1'b0};
        tbl[7] = '{2, 8'h00, 1'b1};
        tbl[8] = '{3, 8'h7F, 1'b0};

        fork
            rx_run(0, 8, 0, 1);
            rx_run(1, 8, 1, 2);
            rx_run(2, 8, 2, 1);
            rx_run(3, 7, 0, 1);
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", int'(tx_a), 15);
        chk("rst_ready", int'(rdy_a), 15);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_cnt", int'(c0) + int'(c1) + int'(c2) + int'(c3), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // T1: exact waveform of 0x55 on 8N1, 4 clocks per symbol
        push(0, 8'h55, 1'b0);
        drop(0);
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (!tx_a[0]) break;
        end
        for (int c = 0; c < 40; c++) begin
            int j, e;
            j = c / 4;
            e = (j == 0) ? 0 : (j == 9) ? 1 : ((8'h55 >> (j - 1)) & 1);
            chk("t1_bit", int'(tx_a[0]), e);
            @(posedge clk); #1;
        end
        chk("t1_idle", int'(tx_a[0]), 1);
        drain();

        // Table of single frames across all configurations
        for (int i = 0; i < 9; i++) begin
            prev = nstart[tbl[i].k];
            push(tbl[i].k, tbl[i].data, tbl[i].par);
            drop(tbl[i].k);
            drain();
            chk("tbl_frames", nstart[tbl[i].k] - prev, 1);
        end

        // T3: depth-4 FIFO with ticks gated off, 6 back-to-back offers
        ten[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] w;
            w = 8'((1 << (i + 1)) - 1);
            @(negedge clk);
            v[1] = 1'b1; d[1] = w;
            chk("t3_ready", int'(rdy_a[1]), int'(i < 5));
            @(posedge clk);
            if (rdy_a[1]) sbq.push_back('{1, {1'b0, w}, ^w});
        end
        drop(1);
        chk("t3_count", int'(c1), 4);
        chk("t3_ready_full", int'(rdy_a[1]), 0);
        chk("t3_busy", int'(busy_a[1]), 1);
        chk("t3_tx_idle", int'(tx_a[1]), 1);
        prev = nstart[1];
        ten[1] = 1'b1;
        wait_start(1, prev);
        chk("t3_count_f0", int'(c1), 4);
        wait_start(1, prev + 1);
        chk("t3_count_f1", int'(c1), 3);
        drain();

        // T4: two stop bits, back-to-back frames start exactly 12 ticks apart
        push(1, 8'hA3, 1'b0);
        push(1, 8'h3C, 1'b0);
        drop(1);
        drain();
        chk("t4_gap", gap[1], 12);

        // T6: 7N1 frame is 9 ticks; push during the pop cycle keeps count at 1
        @(negedge clk);
        v[3] = 1'b1; d[3] = 8'h41;
        @(posedge clk);
        sbq.push_back('{3, 9'h041, 1'b0});
        @(negedge clk);
        chk("t6_count_push", int'(c3), 1);
        d[3] = 8'h2A;
        @(posedge clk);
        sbq.push_back('{3, 9'h02A, 1'b0});
        @(negedge clk);
        v[3] = 1'b0;
        chk("t6_count_pushpop", int'(c3), 1);
        drain();
        chk("t6_gap", gap[3], 9);

        // T5: reset during data bit 3 with 3 words still queued
        prev = nstart[0];
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b0);
        push(0, 8'h44, 1'b0);
        drop(0);
        wait_start(0, prev);
        chk("t5_queued", int'(c0), 3);
        wait_ticks(0, 4);
        @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        chk("t5_tx", int'(tx_a[0]), 1);
        chk("t5_count", int'(c0), 0);
        chk("t5_busy", int'(busy_a[0]), 0);
        chk("t5_ready", int'(rdy_a[0]), 1);
        @(negedge clk);
        rst = 1'b0;
        prev = nstart[0];
        push(0, 8'h5A, 1'b0);
        drop(0);
        drain();
        chk("t5_clean_frames", nstart[0] - prev, 1);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
